// File: rtl/cpu24_pkg.sv
// rtl/cpu24_pkg.sv - shared types and constants for the CPU24 fetch stage
package cpu24_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// rtl/fetch_timeout_cnt.sv - saturating watchdog counter for outstanding fetches
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flags on the same edge the count reaches LIMIT, so the error lands with it.
    assign expired = (cnt_q == LIMIT) || (en && !clr && cnt_q == LIMIT - 1'b1);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC sample, memory req/ack, IR handshake to decode
module instr_fetch
    import cpu24_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              pc_advance,
    output logic              fetch_err,
    output logic [15:0]       fetch_count
);
    fetch_state_t      state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic              fetch_err_q;
    logic [15:0]       fetch_count_q;

    logic pc_aligned;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    assign pc_aligned = word_aligned(pc[1:0]);

    // Watchdog restarts when a request is issued and again when a flush turns WAIT into DROP.
    assign wd_clr = (state_q == ST_IDLE && pc_aligned) ||
                    (state_q == ST_WAIT && flush && !mem_ack);
    assign wd_en  = (state_q == ST_WAIT || state_q == ST_DROP) && !mem_ack;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= DATA_W'(INSTR_NOP);
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pc_aligned) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc;
                        state_q    <= ST_WAIT;
                    end else begin
                        fetch_err_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            instr_q       <= mem_rdata;
                            instr_pc_q    <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        fetch_count_q <= fetch_count_q + 16'd1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (wd_expired) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc_advance  = instr_valid_q & instr_ready;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          pc_advance;
    logic          fetch_err;
    logic [15:0]   fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_advance(pc_advance), .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    // Reference model: outstanding request, doomed-by-flush flag, held instruction.
    bit            m_req, m_doomed, m_held, m_err;
    logic [AW-1:0] m_addr, m_ipc;
    logic [DW-1:0] m_instr;
    logic [15:0]   m_count;
    int            m_wd;

    typedef struct {
        logic [31:0] pc;
        bit          flush, ack;
        logic [31:0] rdata;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        bit          e_adv;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t v(input logic [31:0] p, input bit f, input bit a, input logic [31:0] d,
                               input bit r, input bit rq, input logic [31:0] ad, input bit vl,
                               input logic [31:0] ins, input logic [31:0] ip, input bit adv,
                               input logic [15:0] cnt);
        vec_t t;
        t.pc = p; t.flush = f; t.ack = a; t.rdata = d; t.ready = r;
        t.e_req = rq; t.e_addr = ad; t.e_valid = vl; t.e_instr = ins; t.e_ipc = ip;
        t.e_adv = adv; t.e_count = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_doomed = 0; m_held = 0; m_err = 0;
        m_addr = '0; m_ipc = '0; m_instr = '0; m_count = '0; m_wd = 0;
    endtask

    task automatic model_check();
        chk("m_mem_req", mem_req, m_req);
        chk("m_mem_addr", mem_addr, m_addr);
        chk("m_instr_valid", instr_valid, m_held);
        chk("m_instr", instr, m_instr);
        chk("m_instr_pc", instr_pc, m_ipc);
        chk("m_pc_advance", pc_advance, m_held & instr_ready);
        chk("m_fetch_count", fetch_count, m_count);
        chk("m_fetch_err", fetch_err, m_err);
    endtask

    task automatic model_step();
        if (m_held) begin
            if (flush) m_held = 0;
            else if (instr_ready) begin m_held = 0; m_count = m_count + 16'd1; end
        end else if (m_req) begin
            if (mem_ack) begin
                m_req = 0;
                if (!m_doomed && !flush) begin m_held = 1; m_instr = mem_rdata; m_ipc = m_addr; end
            end else if (flush && !m_doomed) begin
                m_doomed = 1; m_wd = 0;
            end else begin
                if (m_wd < TO) m_wd++;
                if (m_wd == TO) m_err = 1;
            end
        end else begin
            if (pc[1:0] == 2'b00) begin m_req = 1; m_addr = pc; m_doomed = 0; m_wd = 0; end
            else m_err = 1;
        end
    endtask

    task automatic drive(input logic [31:0] p, input bit f, input bit a, input logic [31:0] d, input bit r);
        pc = p; flush = f; mem_ack = a; mem_rdata = d; instr_ready = r;
        #1;
    endtask

    task automatic finish_cycle();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [31:0] p, input bit f, input bit a, input logic [31:0] d, input bit r);
        drive(p, f, a, d, r);
        finish_cycle();
    endtask

    task automatic fetch_one(input logic [31:0] p, input logic [31:0] d);
        cycle(p, 0, 0, 0, 0);
        cycle(p, 0, 1, d, 0);
        cycle(p, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] rpc, rpc_n, rd;
        bit          rf, ra, rr;
        int          n;

        vecs[0]  = v(32'h0, 0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,         32'h0, 0, 16'd0);
        vecs[1]  = v(32'h0, 0, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0,         32'h0, 0, 16'd0);
        vecs[2]  = v(32'h0, 0, 1, 32'h2008_0005, 1, 1, 32'h0, 0, 32'h0,         32'h0, 0, 16'd0);
        vecs[3]  = v(32'h0, 0, 0, 32'h0,         1, 0, 32'h0, 1, 32'h2008_0005, 32'h0, 1, 16'd0);
        vecs[4]  = v(32'h4, 0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h2008_0005, 32'h0, 0, 16'd1);
        vecs[5]  = v(32'h4, 0, 1, 32'h1111_2222, 0, 1, 32'h4, 0, 32'h2008_0005, 32'h0, 0, 16'd1);
        for (int i = 6; i <= 10; i++)
            vecs[i] = v(32'h4, 0, 0, 32'h0, 0, 0, 32'h4, 1, 32'h1111_2222, 32'h4, 0, 16'd1);
        vecs[11] = v(32'h4, 0, 0, 32'h0,         1, 0, 32'h4, 1, 32'h1111_2222, 32'h4, 1, 16'd1);
        vecs[12] = v(32'h8, 0, 0, 32'h0,         0, 0, 32'h4, 0, 32'h1111_2222, 32'h4, 0, 16'd2);

        rst = 1'b0;
        pc = '0; flush = 0; mem_ack = 0; mem_rdata = '0; instr_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_fetch_count", fetch_count, 0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].pc, vecs[i].flush, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
            chk($sformatf("vec%0d_req", i), mem_req, vecs[i].e_req);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].e_ipc);
            chk($sformatf("vec%0d_adv", i), pc_advance, vecs[i].e_adv);
            chk($sformatf("vec%0d_count", i), fetch_count, vecs[i].e_count);
            finish_cycle();
        end

        // Flush while waiting; the late word must be swallowed.
        cycle(32'h8, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(32'h40, (i == 2), (i == 4), (i == 4) ? 32'hDEAD_BEEF : 32'h0, 1);
            chk("drop_req_held", mem_req, 1);
            chk("drop_no_valid", instr_valid, 0);
            finish_cycle();
        end
        drive(32'h40, 0, 0, 0, 1);
        chk("drop_after_req", mem_req, 0);
        chk("drop_after_valid", instr_valid, 0);
        finish_cycle();
        drive(32'h40, 0, 1, 32'hCAFE_0040, 0);
        chk("refetch_addr", mem_addr, 32'h40);
        chk("refetch_req", mem_req, 1);
        finish_cycle();

        // Flush and ready together in HOLD.
        drive(32'h40, 1, 0, 0, 1);
        chk("hold_flush_valid", instr_valid, 1);
        chk("hold_flush_adv", pc_advance, 1);
        finish_cycle();
        drive(32'h40, 0, 0, 0, 0);
        chk("hold_flush_valid_next", instr_valid, 0);
        chk("hold_flush_count", fetch_count, 2);
        finish_cycle();

        rpc = 32'h40;
        for (int i = 0; i < 1500; i++) begin
            ra = m_req && (m_wd >= 5 || $urandom_range(0, 2) == 0);
            rf = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            if (rf) rpc_n = $urandom & 32'h0000_FFFC;
            else if (m_held && rr) rpc_n = rpc + 32'd4;
            else rpc_n = rpc;
            cycle(rpc, rf, ra, rd, rr);
            rpc = rpc_n;
        end

        n = 0;
        while ((m_req || m_held) && n < 12) begin
            cycle(32'h100, 0, m_req, $urandom, 1);
            n++;
        end
        if (n >= 12) begin
            errors++;
            $display("FAIL drain: model still busy after %0d cycles, required idle", n);
        end

        // Watchdog: no ack for TO cycles.
        cycle(32'h100, 0, 0, 0, 0);
        for (int w = 1; w <= 9; w++) begin
            drive(32'h100, 0, 0, 0, 0);
            if (w == 8) chk("wd_not_yet", fetch_err, 0);
            if (w == 9) chk("wd_expired", fetch_err, 1);
            chk("wd_req_held", mem_req, 1);
            finish_cycle();
        end
        cycle(32'h100, 0, 1, 32'h7777_0100, 0);
        cycle(32'h100, 0, 0, 0, 1);
        drive(32'h104, 0, 0, 0, 0);
        chk("err_sticky", fetch_err, 1);
        finish_cycle();

        // Asynchronous reset while waiting.
        instr_ready = 1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_instr", instr, 0);
        chk("arst_instr_pc", instr_pc, 0);
        chk("arst_instr_valid", instr_valid, 0);
        chk("arst_pc_advance", pc_advance, 0);
        chk("arst_fetch_err", fetch_err, 0);
        chk("arst_fetch_count", fetch_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Misaligned PC.
        cycle(32'h6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h6, 0, 0, 0, 0);
            chk("misalign_err", fetch_err, 1);
            chk("misalign_no_req", mem_req, 0);
            finish_cycle();
        end
        fetch_one(32'hC, 32'h0C0C_0C0C);
        chk("after_misalign_count", fetch_count, 1);

        // Counter wrap: preload just below the wrap point.
        force dut.fetch_count_q = 16'hFFFF;
        #1;
        release dut.fetch_count_q;
        m_count = 16'hFFFF;
        fetch_one(32'h10, 32'h1010_1010);
        chk("wrap_zero", fetch_count, 0);
        fetch_one(32'h14, 32'h1414_1414);
        chk("wrap_one", fetch_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
